// File: rtl/super_fft16.sv
// 16-point radix-2 DIT forward DFT of real unsigned samples, one frame per clock.
// There are four butterfly stages, each followed by a register bank, so a frame appears on the outputs 4 clocks after it is sampled.
module super_fft16 #(
   parameter int IN_W    = 8,
   parameter int OUT_W   = 28,
   parameter int TW_FRAC = 8
) (
   output logic signed [OUT_W-1:0] R0,
   output logic signed [OUT_W-1:0] R1,
   output logic signed [OUT_W-1:0] R2,
   output logic signed [OUT_W-1:0] R3,
   output logic signed [OUT_W-1:0] R4,
   output logic signed [OUT_W-1:0] R5,
   output logic signed [OUT_W-1:0] R6,
   output logic signed [OUT_W-1:0] R7,
   output logic signed [OUT_W-1:0] R8,
   output logic signed [OUT_W-1:0] R9,
   output logic signed [OUT_W-1:0] R10,
   output logic signed [OUT_W-1:0] R11,
   output logic signed [OUT_W-1:0] R12,
   output logic signed [OUT_W-1:0] R13,
   output logic signed [OUT_W-1:0] R14,
   output logic signed [OUT_W-1:0] R15,
   output logic signed [OUT_W-1:0] I0,
   output logic signed [OUT_W-1:0] I1,
   output logic signed [OUT_W-1:0] I2,
   output logic signed [OUT_W-1:0] I3,
   output logic signed [OUT_W-1:0] I4,
   output logic signed [OUT_W-1:0] I5,
   output logic signed [OUT_W-1:0] I6,
   output logic signed [OUT_W-1:0] I7,
   output logic signed [OUT_W-1:0] I8,
   output logic signed [OUT_W-1:0] I9,
   output logic signed [OUT_W-1:0] I10,
   output logic signed [OUT_W-1:0] I11,
   output logic signed [OUT_W-1:0] I12,
   output logic signed [OUT_W-1:0] I13,
   output logic signed [OUT_W-1:0] I14,
   output logic signed [OUT_W-1:0] I15,
   input  logic [IN_W-1:0]         X0,
   input  logic [IN_W-1:0]         X1,
   input  logic [IN_W-1:0]         X2,
   input  logic [IN_W-1:0]         X3,
   input  logic [IN_W-1:0]         X4,
   input  logic [IN_W-1:0]         X5,
   input  logic [IN_W-1:0]         X6,
   input  logic [IN_W-1:0]         X7,
   input  logic [IN_W-1:0]         X8,
   input  logic [IN_W-1:0]         X9,
   input  logic [IN_W-1:0]         X10,
   input  logic [IN_W-1:0]         X11,
   input  logic [IN_W-1:0]         X12,
   input  logic [IN_W-1:0]         X13,
   input  logic [IN_W-1:0]         X14,
   input  logic [IN_W-1:0]         X15,
   input  logic                    clk,
   input  logic                    rst
);

   localparam int PW = OUT_W + 10;

   logic [IN_W-1:0]         xs   [16];
   logic signed [OUT_W-1:0] stg_re [4][16];
   logic signed [OUT_W-1:0] stg_im [4][16];
   logic signed [OUT_W-1:0] re_d [4][16];
   logic signed [OUT_W-1:0] im_d [4][16];
   logic signed [OUT_W-1:0] re_q [4][16];
   logic signed [OUT_W-1:0] im_q [4][16];

   function automatic logic [3:0] bitrev(input int unsigned i);
      logic [3:0] v;
      v = 4'(i);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   function automatic logic signed [9:0] tw_c(input int unsigned k);
      case (k)
         0:       return 10'sd256;
         1:       return 10'sd237;
         2:       return 10'sd181;
         3:       return 10'sd98;
         4:       return 10'sd0;
         5:       return -10'sd98;
         6:       return -10'sd181;
         default: return -10'sd237;
      endcase
   endfunction

   function automatic logic signed [9:0] tw_s(input int unsigned k);
      case (k)
         0:       return 10'sd0;
         1:       return 10'sd98;
         2:       return 10'sd181;
         3:       return 10'sd237;
         4:       return 10'sd256;
         5:       return 10'sd237;
         6:       return 10'sd181;
         default: return 10'sd98;
      endcase
   endfunction

   // Computes floor((x*m + y*n) / 2^TW_FRAC). It serves as both the real and the imaginary half of the twiddle multiply.
   function automatic logic signed [OUT_W-1:0] mac_shift(
      input logic signed [OUT_W-1:0] x,
      input logic signed [OUT_W-1:0] y,
      input logic signed [9:0]       m,
      input logic signed [9:0]       n
   );
      logic signed [PW-1:0] acc;
      acc = PW'(x) * PW'(m) + PW'(y) * PW'(n);
      acc = acc >>> TW_FRAC;
      return acc[OUT_W-1:0];
   endfunction

   assign xs[0]  = X0;
   assign xs[1]  = X1;
   assign xs[2]  = X2;
   assign xs[3]  = X3;
   assign xs[4]  = X4;
   assign xs[5]  = X5;
   assign xs[6]  = X6;
   assign xs[7]  = X7;
   assign xs[8]  = X8;
   assign xs[9]  = X9;
   assign xs[10] = X10;
   assign xs[11] = X11;
   assign xs[12] = X12;
   assign xs[13] = X13;
   assign xs[14] = X14;
   assign xs[15] = X15;

   always_comb begin
      logic signed [OUT_W-1:0] w_re;
      logic signed [OUT_W-1:0] w_im;
      int unsigned h;
      int unsigned k;
      w_re = '0;
      w_im = '0;
      h    = 0;
      k    = 0;
      for (int unsigned i = 0; i < 16; i++) begin
         stg_re[0][i] = $signed({{(OUT_W-IN_W){1'b0}}, xs[bitrev(i)]});
         stg_im[0][i] = '0;
      end
      for (int unsigned s = 1; s < 4; s++) begin
         for (int unsigned i = 0; i < 16; i++) begin
            stg_re[s][i] = re_q[s-1][i];
            stg_im[s][i] = im_q[s-1][i];
         end
      end
      for (int unsigned s = 0; s < 4; s++) begin
         for (int unsigned i = 0; i < 16; i++) begin
            re_d[s][i] = '0;
            im_d[s][i] = '0;
         end
      end
      // Butterfly with upper leg i and lower leg i+h. The twiddle exponent is the offset of i within its group.
      for (int unsigned s = 0; s < 4; s++) begin
         h = 1 << s;
         for (int unsigned i = 0; i < 16; i++) begin
            if ((i & h) == 0) begin
               k    = (i & (h - 1)) * (8 >> s);
               w_re = mac_shift(stg_re[s][i+h], stg_im[s][i+h], tw_c(k), tw_s(k));
               w_im = mac_shift(stg_im[s][i+h], stg_re[s][i+h], tw_c(k), -tw_s(k));
               re_d[s][i]   = stg_re[s][i] + w_re;
               im_d[s][i]   = stg_im[s][i] + w_im;
               re_d[s][i+h] = stg_re[s][i] - w_re;
               im_d[s][i+h] = stg_im[s][i] - w_im;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < 4; s++) begin
            for (int unsigned i = 0; i < 16; i++) begin
               re_q[s][i] <= '0;
               im_q[s][i] <= '0;
            end
         end
      end else begin
         re_q <= re_d;
         im_q <= im_d;
      end
   end

   assign R0  = re_q[3][0];
   assign R1  = re_q[3][1];
   assign R2  = re_q[3][2];
   assign R3  = re_q[3][3];
   assign R4  = re_q[3][4];
   assign R5  = re_q[3][5];
   assign R6  = re_q[3][6];
   assign R7  = re_q[3][7];
   assign R8  = re_q[3][8];
   assign R9  = re_q[3][9];
   assign R10 = re_q[3][10];
   assign R11 = re_q[3][11];
   assign R12 = re_q[3][12];
   assign R13 = re_q[3][13];
   assign R14 = re_q[3][14];
   assign R15 = re_q[3][15];
   assign I0  = im_q[3][0];
   assign I1  = im_q[3][1];
   assign I2  = im_q[3][2];
   assign I3  = im_q[3][3];
   assign I4  = im_q[3][4];
   assign I5  = im_q[3][5];
   assign I6  = im_q[3][6];
   assign I7  = im_q[3][7];
   assign I8  = im_q[3][8];
   assign I9  = im_q[3][9];
   assign I10 = im_q[3][10];
   assign I11 = im_q[3][11];
   assign I12 = im_q[3][12];
   assign I13 = im_q[3][13];
   assign I14 = im_q[3][14];
   assign I15 = im_q[3][15];

endmodule

// File: tb/tb_super_fft16.sv
// Bench for super_fft16: a scoreboard queue holds per-edge expected spectra, and the scenario tasks add fixed-value checks.
module tb_super_fft16;

   typedef struct {
      longint re [16];
      longint im [16];
   } frame_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [7:0]          x  [16];
   logic signed [27:0]  r  [16];
   logic signed [27:0]  im [16];

   frame_t sb [$];
   bit     primed = 1'b0;
   int     checks = 0;
   int     errors = 0;

   always #5 clk = ~clk;

   super_fft16 #(.IN_W(8), .OUT_W(28), .TW_FRAC(8)) dut (
      .R0(r[0]),   .R1(r[1]),   .R2(r[2]),   .R3(r[3]),
      .R4(r[4]),   .R5(r[5]),   .R6(r[6]),   .R7(r[7]),
      .R8(r[8]),   .R9(r[9]),   .R10(r[10]), .R11(r[11]),
      .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
      .I0(im[0]),   .I1(im[1]),   .I2(im[2]),   .I3(im[3]),
      .I4(im[4]),   .I5(im[5]),   .I6(im[6]),   .I7(im[7]),
      .I8(im[8]),   .I9(im[9]),   .I10(im[10]), .I11(im[11]),
      .I12(im[12]), .I13(im[13]), .I14(im[14]), .I15(im[15]),
      .X0(x[0]),   .X1(x[1]),   .X2(x[2]),   .X3(x[3]),
      .X4(x[4]),   .X5(x[5]),   .X6(x[6]),   .X7(x[7]),
      .X8(x[8]),   .X9(x[9]),   .X10(x[10]), .X11(x[11]),
      .X12(x[12]), .X13(x[13]), .X14(x[14]), .X15(x[15]),
      .clk(clk),
      .rst(rst)
   );

   // Reference model: an in-place iterative FFT on longints using the rounded twiddle table.
   function automatic frame_t model(input logic [7:0] xs [16]);
      frame_t f;
      longint ctab [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
      longint stab [8] = '{0, 98, 181, 237, 256, 237, 181, 98};
      longint tr, ti;
      logic [3:0] n;
      for (int i = 0; i < 16; i++) begin
         n = 4'(i);
         f.re[i] = longint'(xs[{n[0], n[1], n[2], n[3]}]);
         f.im[i] = 0;
      end
      for (int len = 2; len <= 16; len = len * 2) begin
         for (int base = 0; base < 16; base += len) begin
            for (int j = 0; j < len / 2; j++) begin
               int     k;
               int     lo;
               longint ar, ai;
               k  = j * (16 / len);
               lo = base + j + len / 2;
               tr = (f.re[lo] * ctab[k] + f.im[lo] * stab[k]) >>> 8;
               ti = (f.im[lo] * ctab[k] - f.re[lo] * stab[k]) >>> 8;
               ar = f.re[base + j];
               ai = f.im[base + j];
               f.re[base + j] = ar + tr;
               f.im[base + j] = ai + ti;
               f.re[lo]       = ar - tr;
               f.im[lo]       = ai - ti;
            end
         end
      end
      return f;
   endfunction

   // One clock edge. Push the expectation for what the DUT samples on this edge, then pop the expectation that is due now and compare.
   task automatic tick();
      bit     rs;
      frame_t e;
      frame_t z;
      rs = rst;
      for (int i = 0; i < 16; i++) begin
         z.re[i] = 0;
         z.im[i] = 0;
      end
      e = model(x);
      @(posedge clk);
      #1;
      if (rs) begin
         sb.delete();
         for (int i = 0; i < 4; i++) sb.push_back(z);
         primed = 1'b1;
      end else if (primed) begin
         sb.push_back(e);
      end
      if (primed && sb.size() > 0) begin
         e = sb.pop_front();
         for (int b = 0; b < 16; b++) begin
            checks++;
            if (r[b] !== 28'(e.re[b])) begin
               errors++;
               $display("FAIL sb_R%0d t=%0t got %0d want %0d", b, $time, r[b], e.re[b]);
            end
            checks++;
            if (im[b] !== 28'(e.im[b])) begin
               errors++;
               $display("FAIL sb_I%0d t=%0t got %0d want %0d", b, $time, im[b], e.im[b]);
            end
         end
      end
   endtask

   task automatic set_all(input logic [7:0] v);
      for (int i = 0; i < 16; i++) x[i] = v;
   endtask

   task automatic set_mixed();
      logic [7:0] mv [16] = '{80, 38, 182, 112, 72, 84, 232, 84, 40, 116, 104, 52, 184, 116, 46, 116};
      for (int i = 0; i < 16; i++) x[i] = mv[i];
   endtask

   task automatic set_impulse();
      set_all(8'd0);
      x[0] = 8'd100;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 16; i++) x[i] = 8'($urandom_range(0, 255));
         tick();
      end
      for (int b = 0; b < 16; b++) begin
         checks++;
         if (r[b] !== 28'sd0 || im[b] !== 28'sd0) begin
            errors++;
            $display("FAIL reset_bin%0d got R=%0d I=%0d want 0", b, r[b], im[b]);
         end
      end
      rst = 1'b0;
      set_all(8'd0);
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_dc();
      set_all(8'd1);
      tick();
      set_all(8'd0);
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (r[0] !== 28'sd16) begin
         errors++;
         $display("FAIL dc_R0 got %0d want 16", r[0]);
      end
      for (int b = 1; b < 16; b++) begin
         checks++;
         if (r[b] !== 28'sd0 || im[b] !== 28'sd0) begin
            errors++;
            $display("FAIL dc_bin%0d got R=%0d I=%0d want 0", b, r[b], im[b]);
         end
      end
   endtask

   task automatic test_impulse();
      set_impulse();
      tick();
      set_all(8'd0);
      for (int c = 0; c < 3; c++) tick();
      for (int b = 0; b < 16; b++) begin
         checks++;
         if (r[b] !== 28'sd100 || im[b] !== 28'sd0) begin
            errors++;
            $display("FAIL impulse_bin%0d got R=%0d I=%0d want 100/0", b, r[b], im[b]);
         end
      end
   endtask

   task automatic test_alternating();
      for (int i = 0; i < 16; i++) x[i] = (i % 2 == 0) ? 8'd10 : 8'd0;
      tick();
      set_all(8'd0);
      for (int c = 0; c < 3; c++) tick();
      for (int b = 0; b < 16; b++) begin
         checks++;
         if (r[b] !== ((b == 0 || b == 8) ? 28'sd80 : 28'sd0) || im[b] !== 28'sd0) begin
            errors++;
            $display("FAIL alt_bin%0d got R=%0d I=%0d", b, r[b], im[b]);
         end
      end
   endtask

   task automatic test_mixed();
      set_mixed();
      tick();
      set_all(8'd0);
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (r[0] !== 28'sd1658 || im[0] !== 28'sd0) begin
         errors++;
         $display("FAIL mixed_bin0 got R=%0d I=%0d want 1658/0", r[0], im[0]);
      end
      checks++;
      if (r[8] !== 28'sd222 || im[8] !== 28'sd0) begin
         errors++;
         $display("FAIL mixed_bin8 got R=%0d I=%0d want 222/0", r[8], im[8]);
      end
   endtask

   task automatic test_back_to_back();
      set_all(8'd1);
      tick();
      set_impulse();
      tick();
      set_mixed();
      tick();
      set_all(8'd0);
      tick();
      checks++;
      if (r[0] !== 28'sd16 || r[3] !== 28'sd0) begin
         errors++;
         $display("FAIL b2b_dc got R0=%0d R3=%0d want 16/0", r[0], r[3]);
      end
      tick();
      checks++;
      if (r[5] !== 28'sd100 || im[5] !== 28'sd0) begin
         errors++;
         $display("FAIL b2b_impulse got R5=%0d I5=%0d want 100/0", r[5], im[5]);
      end
      tick();
      checks++;
      if (r[0] !== 28'sd1658 || r[8] !== 28'sd222) begin
         errors++;
         $display("FAIL b2b_mixed got R0=%0d R8=%0d want 1658/222", r[0], r[8]);
      end
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < 16; i++) x[i] = 8'($urandom_range(0, 255));
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      set_all(8'd1);
      tick();
      set_impulse();
      tick();
      set_mixed();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_all(8'd0);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (r[0] !== 28'sd0 || r[5] !== 28'sd0) begin
            errors++;
            $display("FAIL midrst_c%0d got R0=%0d R5=%0d want 0", c, r[0], r[5]);
         end
         tick();
      end
      set_all(8'd3);
      for (int c = 0; c < 6; c++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      set_all(8'd0);
      test_reset();
      test_dc();
      test_impulse();
      test_alternating();
      test_mixed();
      test_back_to_back();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/super_fft16.md
Name: super_fft16

Overview:
- 16-point fixed-point forward DFT engine (radix-2 decimation-in-time) for real 8-bit samples.
- Each clock it accepts one 16-sample real frame and produces 16 complex bins, split into real and imaginary outputs.
- Fully pipelined: one frame in and one frame out per cycle after fill.
- Sits after the sample buffer in the signal-decode path and feeds downstream spectral logic.

Parameters:
- IN_W, 8, input sample width; samples are unsigned.
- OUT_W, 28, output width per real or imaginary component; outputs are two's-complement.
- TW_FRAC, 8, twiddle fraction bits; 1.0 is represented as 256.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- X0..X15  input  8 each  frame samples x[0]..x[15], unsigned.
- R0..R15  output  28 each  Re(X[k]) for bin k, signed.
- I0..I15  output  28 each  Im(X[k]) for bin k, signed.
- Port order: R0..R15, I0..I15, X0..X15, clk, rst.

Behaviour:
- Transform: X[k] = sum over n of x[n]·e^(−j2πnk/16), k = 0..15. Outputs are in natural order.
- No per-stage scaling. Maximum magnitude is 16·255 = 4080, so 28 bits cannot overflow.
- Inputs are zero-extended to OUT_W signed. Imaginary input = 0.
- Structure:
  - Inputs are taken in bit-reversed order.
  - 4 radix-2 stages; stage s has butterfly span 2^(s−1).
  - Each butterfly computes a' = a + W·b and b' = a − W·b.
  - Twiddle exponent k = j·16/2^s.
- Twiddle W^k = c − j·s, with c = round(256·cos(2πk/16)) and s = round(256·sin(2πk/16)). (c, s) values:
  - k=0: (256, 0); k=1: (237, 98); k=2: (181, 181); k=3: (98, 237).
  - k=4: (0, 256); k=5: (−98, 237); k=6: (−181, 181); k=7: (−237, 98).
- Complex multiply:
  - Re = (br·c + bi·s) >>> 8.
  - Im = (bi·c − br·s) >>> 8.
  - >>> is an arithmetic shift, i.e. floor. Intermediate products are at least OUT_W+10 bits.
  - k=0 and k=4 are exact and may be implemented as wire swap/negate, provided results are bit-identical.
- Pipeline: one register bank after each of the 4 stages, so latency is 4 clocks.
  - The frame sampled on edge N appears on R/I after edge N+3, i.e. valid in the cycle following edge N+3.
  - Throughput is one frame per clock. No handshake; inputs are sampled every edge.
- Reset: when rst=1 at an edge, all pipeline registers clear.
  - All R and I outputs read 0 from the next cycle.
  - Frames in flight are discarded.
  - After rst falls, outputs show 0 until the first post-reset frame emerges 4 edges later.
- Power-up before the first reset: outputs are undefined (X allowed).
- I0 and I8 are always exactly 0 for any input.

Test Plan:
- Reset: drive rst=1 for 2 edges with arbitrary X → all R/I = 0. Release with X all 0 → outputs remain 0.
- DC frame: all X=1 → after 4 edges R0=16, all other R=0, all I=0.
- Impulse: X0=100, others 0 → every Rk=100, every Ik=0.
- Alternating: even X=10, odd X=0 → R0=80, R8=80, all other R and I = 0.
- Mixed vector: X0..X15 = 80, 38, 182, 112, 72, 84, 232, 84, 40, 116, 104, 52, 184, 116, 46, 116 → R0=1658, I0=0, R8=222, I8=0. All bins also match a bit-accurate model of the algorithm above.
- Pipelining: apply the DC, impulse and mixed frames on 3 consecutive edges → the three results appear on 3 consecutive cycles, 4 edges later. Assert rst mid-stream → all in-flight frames are lost and outputs read 0.
